// File: rtl/led_blink_scheduler_if.sv
// led_blink_scheduler_if: request/grant/LED bundle between status sources and the blink scheduler
interface led_blink_scheduler_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0] REQ;
    logic [N_REQ-1:0] GRANT;
    logic             BUSY;
    logic [1:0]       LED;
    logic             DONE;
    modport master (output REQ, input GRANT, BUSY, LED, DONE);
    modport slave  (input REQ, output GRANT, BUSY, LED, DONE);
endinterface

// File: rtl/led_blink_scheduler.sv
// led_blink_scheduler: round-robin sharing of the two-LED blinker, fixed blink burst per grant
module led_blink_scheduler #(
    parameter int HALF_PERIOD      = 50000000,
    parameter int BLINKS_PER_GRANT = 3,
    parameter int N_REQ            = 4
) (
    input logic                  CLOCK_50,
    input logic                  RESET,
    led_blink_scheduler_if.slave bus
);
    localparam int PW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int BW = $clog2(BLINKS_PER_GRANT + 1);
    localparam int RW = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    phase_q, phase_d;
    logic [BW-1:0]    blink_q, blink_d;
    logic [RW-1:0]    ptr_q, ptr_d;
    logic [RW-1:0]    owner_q, owner_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [1:0]       led_q, led_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [RW:0]   sum;
    logic [RW-1:0] idx, win, owner_next;
    logic [BW-1:0] blink_n;
    logic          found, phase_end;

    assign owner_next = (owner_q == RW'(N_REQ - 1)) ? '0 : owner_q + RW'(1);
    assign blink_n    = blink_q + BW'(1);
    assign phase_end  = phase_q == PW'(HALF_PERIOD - 1);

    // first requester at or after ptr, wrapping modulo N_REQ
    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sum = {1'b0, ptr_q} + (RW+1)'(i);
            sum = (sum >= (RW+1)'(N_REQ)) ? sum - (RW+1)'(N_REQ) : sum;
            idx = sum[RW-1:0];
            if (!found && bus.REQ[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        blink_d = blink_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        grant_d = grant_q;
        led_d   = led_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (found) begin
                state_d = ON;
                owner_d = win;
                grant_d = N_REQ'(1) << win;
                led_d   = 2'b01;
                busy_d  = 1'b1;
                phase_d = '0;
                blink_d = '0;
            end
        end else if (!bus.REQ[owner_q] || (state_q == OFF && phase_end && blink_n == BW'(BLINKS_PER_GRANT))) begin
            // withdrawal wins over a phase end, so DONE only marks a held request finishing
            state_d = IDLE;
            grant_d = '0;
            led_d   = 2'b00;
            busy_d  = 1'b0;
            done_d  = bus.REQ[owner_q];
            ptr_d   = owner_next;
            phase_d = '0;
            blink_d = '0;
        end else if (phase_end) begin
            state_d = (state_q == ON) ? OFF : ON;
            led_d   = (state_q == ON) ? 2'b10 : 2'b01;
            blink_d = (state_q == OFF) ? blink_n : blink_q;
            phase_d = '0;
        end else begin
            phase_d = phase_q + PW'(1);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q <= IDLE;
            phase_q <= '0;
            blink_q <= '0;
            ptr_q   <= '0;
            owner_q <= '0;
            grant_q <= '0;
            led_q   <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            blink_q <= blink_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.GRANT = grant_q;
    assign bus.BUSY  = busy_q;
    assign bus.LED   = led_q;
    assign bus.DONE  = done_q;
endmodule

// File: tb/tb_led_blink_scheduler.sv
// tb_led_blink_scheduler: directed stimulus with a grant-record scoreboard and per-cycle output monitor
module tb_led_blink_scheduler;
    localparam int HP = 4;
    localparam int BPG = 2;
    localparam int FULL = 2 * HP * BPG;

    typedef struct {
        int g;
        int len;
        int done;
        int gap;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic started = 1'b0;
    logic rst_at_edge = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t sb[$];

    led_blink_scheduler_if #(.N_REQ(4)) bus ();

    led_blink_scheduler #(.HALF_PERIOD(HP), .BLINKS_PER_GRANT(BPG), .N_REQ(4)) dut (
        .CLOCK_50(clk),
        .RESET(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rst_at_edge <= rst;
        started     <= 1'b1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic push(input int g, input int len, input int done, input int gap);
        exp_t e;
        e = '{g, len, done, gap};
        sb.push_back(e);
    endtask

    task automatic wait_done();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.DONE && k < 100);
        chk("done_seen", int'(bus.DONE), 1);
    endtask

    int   prev_g = 0;
    int   cur_len = 0;
    int   start_gap = 0;
    int   idle_cnt = 0;
    int   g;
    exp_t e;

    always @(negedge clk) begin
        if (started) begin
            g = int'(bus.GRANT);
            chk("busy", int'(bus.BUSY), int'(|bus.GRANT));
            if (rst_at_edge) chk("reset_outputs", int'({bus.GRANT, bus.LED, bus.BUSY, bus.DONE}), 0);
            if (g != 0) begin
                if (prev_g == 0) begin
                    cur_len   = 0;
                    start_gap = idle_cnt;
                end else begin
                    chk("grant_stable", g, prev_g);
                end
                chk("led", int'(bus.LED), ((cur_len / HP) % 2 == 1) ? 2 : 1);
                cur_len++;
            end else begin
                chk("led_idle", int'(bus.LED), 0);
                if (prev_g != 0) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_grant", prev_g, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("grant", prev_g, e.g);
                        chk("grant_len", cur_len, e.len);
                        chk("done_at_end", int'(bus.DONE), e.done);
                        if (e.gap >= 0) chk("idle_gap", start_gap, e.gap);
                    end
                    idle_cnt = 1;
                end else begin
                    chk("spurious_done", int'(bus.DONE), 0);
                    idle_cnt++;
                end
            end
            prev_g = g;
        end
    end

    initial begin
        bus.REQ = 4'b1111;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        push(4'b0001, FULL, 1, -1);
        push(4'b0010, FULL, 1, 1);
        push(4'b0100, FULL, 1, 1);
        push(4'b1000, FULL, 1, 1);
        push(4'b0001, FULL, 1, 1);
        repeat (5) wait_done();
        bus.REQ = 4'b0001;
        push(4'b0001, FULL, 1, 1);
        push(4'b0001, FULL, 1, 1);
        repeat (2) wait_done();
        bus.REQ = 4'b0100;
        push(4'b0100, 5, 0, 1);
        repeat (5) @(posedge clk);
        #1 bus.REQ = 4'b0000;
        @(posedge clk);
        #1 bus.REQ = 4'b1111;
        push(4'b1000, FULL, 1, 1);
        wait_done();
        bus.REQ = 4'b0100;
        push(4'b0100, FULL, 1, 1);
        wait_done();
        bus.REQ = 4'b0011;
        push(4'b0001, FULL, 1, 1);
        wait_done();
        bus.REQ = 4'b0010;
        push(4'b0010, 6, 0, 1);
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        bus.REQ = 4'b0011;
        push(4'b0001, FULL, 1, 1);
        wait_done();
        bus.REQ = 4'b0000;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("queue_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end
endmodule

// File: doc/led_blink_scheduler.md
# led_blink_scheduler

Round-robin scheduler that shares the board's two-LED blink output between up to N_REQ requesters. Each granted requester gets a fixed burst of BLINKS_PER_GRANT full on/off blinks, timed by an internal half-period counter on CLOCK_50. Arbitration then moves to the next requester. The block sits between status sources (error flags, heartbeat, debug events) and the LED pins, replacing a free-running single-source blinker.

## Interface
- HALF_PERIOD, 50000000: CLOCK_50 cycles per LED phase (on or off); must be ≥1.
- BLINKS_PER_GRANT, 3: full on+off blinks per grant; must be ≥1.
- N_REQ, 4: number of requesters; must be ≥2.
- CLOCK_50  in  1  system clock; all logic on rising edge.
- RESET  in  1  reset; one clock; reset is synchronous and active-high.
- REQ  in  N_REQ  level requests, one bit per requester, sampled each edge.
- GRANT  out  N_REQ  registered one-hot owner of the LEDs; all-zero when idle.
- BUSY  out  1  high whenever GRANT ≠ 0.
- LED  out  2  LED[0]=phase, LED[1]=~phase while granted; 2'b00 when idle.
- DONE  out  1  one-cycle pulse when a grant completes all its blinks.

## Operation
- States: IDLE, ON, OFF.
- Internal registers:
  - phase counter, width $clog2(HALF_PERIOD), minimum 1.
  - blink counter, width $clog2(BLINKS_PER_GRANT+1).
  - round-robin pointer ptr, width $clog2(N_REQ).
  - owner index.
- IDLE:
  - If REQ ≠ 0, winner = first set bit scanning from ptr upward, wrapping past N_REQ-1 to 0.
  - Next state ON, GRANT = onehot(winner), LED = 2'b01, counters cleared.
  - If REQ = 0, stay in IDLE.
- ON:
  - Phase counter increments each cycle.
  - At count = HALF_PERIOD-1: go to OFF, LED = 2'b10, counter cleared.
- OFF:
  - At count = HALF_PERIOD-1, blink counter increments.
  - If the new value = BLINKS_PER_GRANT: go to IDLE, GRANT = 0, LED = 00, DONE = 1 for one cycle, ptr = (owner+1) mod N_REQ.
  - Otherwise: go to ON, LED = 01.
- Request withdrawal:
  - If REQ[owner] = 0 in ON or OFF, the next edge forces IDLE, GRANT = 0, LED = 00.
  - No DONE pulse; ptr = (owner+1) mod N_REQ.
  - Withdrawal takes precedence over a phase-end on the same edge.
- Requests from non-owners during a grant are ignored; no preemption and no queueing beyond the REQ level.
- Requests must be held until granted.
- RESET (synchronous, any state, including mid-grant), at the next edge:
  - State IDLE, GRANT = 0, BUSY = 0, LED = 2'b00, DONE = 0, ptr = 0, all counters 0.
  - RESET overrides all other events on that edge.

## Timing
- Reset values: GRANT = 0, BUSY = 0, LED = 00, DONE = 0.
- Latency REQ→GRANT: one edge when in IDLE; the request is sampled on edge k and GRANT is visible after edge k.
- Grant duration: exactly 2·HALF_PERIOD·BLINKS_PER_GRANT cycles with GRANT ≠ 0.
- After completion or withdrawal, GRANT is zero for exactly one cycle (the IDLE cycle) before the next grant. Back-to-back spacing is 2·HALF_PERIOD·BLINKS_PER_GRANT + 1 cycles.
- DONE is high in the same cycle that GRANT first reads 0 after completion.
- BUSY = |GRANT, registered and aligned with GRANT.
- LED changes only on phase boundaries, grant start or grant end; no glitch cycles.

## Test plan
Bench parameters: HALF_PERIOD = 4, BLINKS_PER_GRANT = 2, N_REQ = 4.
- **Reset:** RESET = 1 for 3 cycles with REQ = 1111. Required: GRANT = 0000, LED = 00, BUSY = 0, DONE = 0 throughout. First grant after release is 0001.
- **Single requester:** REQ = 0001 held. Required:
  - GRANT = 0001 one edge later.
  - LED sequence 01×4, 10×4, 01×4, 10×4.
  - Then GRANT = 0000, LED = 00, DONE = 1 for one cycle.
  - Re-grant 0001 after one idle cycle.
- **Round-robin:** REQ = 1111 held. Required: grants 0001, 0010, 0100, 1000, 0001, each 16 cycles, starts 17 cycles apart, one DONE per grant.
- **Withdrawal:** REQ = 0100. Drop the bit after 5 granted cycles. Required:
  - Next edge GRANT = 0000, LED = 00, no DONE.
  - Then REQ = 1111 grants 1000 (ptr = 3).
- **Wrap:** after a completed grant to requester 2, REQ = 0011. Required: grant 0001, not 0010.
- **Reset mid-grant:** RESET pulsed one cycle at cycle 6 of a grant to requester 1. Required: next edge all outputs at reset values. With REQ = 0011, the next grant is 0001.
